byte_mux_serializer: RTL and testbench

- Upstream feeder for the `mux_8to1` stage: accepts a byte over a valid/ready handshake and presents it on the mux data inputs (`I7..I0`).
- Steps the 3-bit select (`B2..B0`) through all eight positions at a programmable rate, so the mux output `O` becomes a serial bit stream.
- Emits per-bit and per-frame strobes for downstream consumers.
- Optionally checks the mux output fed back from the stage, counting mismatches.

---
 rtl/byte_mux_serializer.sv | 211 +++++++++++++++++++++
 tb/tb_byte_mux_serializer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_mux_serializer.sv
// ---------------------------------------------------------------------------
// byte_mux_serializer
//
// Feeds a downstream 8:1 mux stage. A byte accepted over a valid/ready
// handshake is presented on the mux data inputs. The 3-bit select is then
// stepped through all eight positions, holding each one for BIT_CYCLES clocks,
// so the mux output becomes a serial bit stream. Per-bit and per-frame strobes
// are produced for downstream consumers. Back-to-back frames run with no gap.
//
// Parameters:
//   BIT_CYCLES  clocks each select value is held (legal range 1..16)
//   MSB_FIRST   0: sel steps 0 -> 7, 1: sel steps 7 -> 0
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   din[7:0]     in   byte to serialize
//   din_valid    in   din is valid
//   din_ready    out  a byte can be accepted this cycle
//   i_bus[7:0]   out  mux data inputs {I7..I0}
//   sel[2:0]     out  mux select {B2,B1,B0}
//   bit_valid    out  sel/i_bus present a live bit
//   frame_start  out  first cycle of the first bit of a frame
//   frame_end    out  last cycle of the last bit of a frame
//   o_fb         in   mux output fed back (used only by the error checker)
//   err_cnt[7:0] out  saturating feedback mismatch count
//   err_flag     out  sticky feedback mismatch flag
//
// Build option:
//   SER_ERRCHK_EN  when defined, o_fb is compared with i_bus[sel] on the last
//                  cycle of every live bit. When undefined, o_fb is ignored
//                  and err_cnt/err_flag are tied to zero.
// ---------------------------------------------------------------------------
module byte_mux_serializer #(
  parameter int BIT_CYCLES = 2,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic [7:0] i_bus,
  output logic [2:0] sel,
  output logic       bit_valid,
  output logic       frame_start,
  output logic       frame_end,
  input  logic       o_fb,
  output logic [7:0] err_cnt,
  output logic       err_flag
);

  // -------------------------------------------------------------------------
  // Configuration guard
  // -------------------------------------------------------------------------
  generate
    if ((BIT_CYCLES < 1) || (BIT_CYCLES > 16)) begin : g_bad_bit_cycles
      $error("byte_mux_serializer: BIT_CYCLES must be within 1..16");
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Constants
  // -------------------------------------------------------------------------
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  localparam logic [2:0] FIRST_SEL = MSB_FIRST ? 3'd7 : 3'd0;
  localparam logic [2:0] LAST_SEL  = MSB_FIRST ? 3'd0 : 3'd7;

  // A 4-bit counter covers the largest hold time of 16 cycles (0..15).
  localparam logic [3:0] LAST_CNT = 4'(BIT_CYCLES - 1);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [0:0] state_reg, state_next;
  logic [3:0] cnt_reg,   cnt_next;
  logic [2:0] sel_reg,   sel_next;
  logic [7:0] i_bus_reg, i_bus_next;

  logic       is_shift;
  logic       bit_last;
  logic       frame_last;
  logic       accept;
  logic [2:0] sel_step;

  assign is_shift   = (state_reg == ST_SHIFT);
  // Final clock of the bit currently on the mux.
  assign bit_last   = is_shift && (cnt_reg == LAST_CNT);
  // Final clock of the whole frame; this is also the reload window that lets
  // the next byte follow without a gap.
  assign frame_last = bit_last && (sel_reg == LAST_SEL);

  assign din_ready  = !is_shift || frame_last;
  assign accept     = din_valid && din_ready;

  assign sel_step   = MSB_FIRST ? (sel_reg - 3'd1) : (sel_reg + 3'd1);

  // -------------------------------------------------------------------------
  // Next-state logic
  //
  // An accept can only happen in IDLE or on frame_last, so it takes priority
  // over ordinary stepping: both cases load the byte and restart at FIRST.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    sel_next   = sel_reg;
    i_bus_next = i_bus_reg;

    if (accept) begin
      state_next = ST_SHIFT;
      i_bus_next = din;
      sel_next   = FIRST_SEL;
      cnt_next   = 4'd0;
    end else if (is_shift) begin
      if (bit_last) begin
        cnt_next = 4'd0;
        if (sel_reg == LAST_SEL) begin
          // Frame done with nothing queued: park sel at FIRST in IDLE.
          state_next = ST_IDLE;
          sel_next   = FIRST_SEL;
        end else begin
          sel_next = sel_step;
        end
      end else begin
        cnt_next = cnt_reg + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 4'd0;
      sel_reg   <= FIRST_SEL;
      i_bus_reg <= 8'h00;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      sel_reg   <= sel_next;
      i_bus_reg <= i_bus_next;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  //
  // The strobes are decoded from registered state, so they drop together with
  // the state on an asynchronous reset and a frame cut short never shows
  // frame_end.
  // -------------------------------------------------------------------------
  assign i_bus       = i_bus_reg;
  assign sel         = sel_reg;
  assign bit_valid   = is_shift;
  assign frame_start = is_shift && (sel_reg == FIRST_SEL) && (cnt_reg == 4'd0);
  assign frame_end   = frame_last;

  // -------------------------------------------------------------------------
  // Feedback checker
  // -------------------------------------------------------------------------
`ifdef SER_ERRCHK_EN
  logic [7:0] sel_onehot;
  logic       expected_bit;
  logic       mismatch;
  logic [7:0] err_cnt_reg,  err_cnt_next;
  logic       err_flag_reg, err_flag_next;

  // One-hot select decode mirrors what the external mux does with B2..B0.
  for (genvar gi = 0; gi < 8; gi++) begin : g_sel_decode
    assign sel_onehot[gi] = (sel_reg == 3'(gi));
  end

  assign expected_bit = |(sel_onehot & i_bus_reg);
  // Compare late in the bit so the loop through the mux has settled.
  assign mismatch     = bit_last && (o_fb != expected_bit);

  always_comb begin
    err_cnt_next  = err_cnt_reg;
    err_flag_next = err_flag_reg;
    if (mismatch) begin
      err_flag_next = 1'b1;
      if (err_cnt_reg != 8'hFF) begin
        err_cnt_next = err_cnt_reg + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_reg  <= 8'd0;
      err_flag_reg <= 1'b0;
    end else begin
      err_cnt_reg  <= err_cnt_next;
      err_flag_reg <= err_flag_next;
    end
  end

  assign err_cnt  = err_cnt_reg;
  assign err_flag = err_flag_reg;
`else
  // Without the checker the feedback input has no consumer.
  logic unused_fb;
  assign unused_fb = o_fb;

  assign err_cnt   = 8'd0;
  assign err_flag  = 1'b0;
`endif

endmodule

// File: tb/tb_byte_mux_serializer.sv
// ---------------------------------------------------------------------------
// tb_byte_mux_serializer
//
// Two instances share clock and reset:
//   dut_a  BIT_CYCLES=2, LSB first
//   dut_b  BIT_CYCLES=1, MSB first
// A behavioural 8:1 mux on each instance closes the o_fb loop. Frames come
// from a table of {byte, instance, expected serial stream, next-byte timing};
// reset mid-frame, random traffic and a forced-feedback error case are
// hand-written sequences.
// ---------------------------------------------------------------------------
module tb_byte_mux_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] din;
  logic       valid_a, valid_b;
  logic       fb_force0;

  logic       ready_a, ready_b;
  logic [7:0] i_bus_a, i_bus_b;
  logic [2:0] sel_a, sel_b;
  logic       bv_a, bv_b, fs_a, fs_b, fe_a, fe_b;
  logic       o_fb_a, o_fb_b;
  logic [7:0] err_cnt_a, err_cnt_b;
  logic       err_flag_a, err_flag_b;

  // Downstream mux model: O = I[sel].
  assign o_fb_a = fb_force0 ? 1'b0 : i_bus_a[sel_a];
  assign o_fb_b = i_bus_b[sel_b];

  byte_mux_serializer #(.BIT_CYCLES(2), .MSB_FIRST(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(valid_a),
    .din_ready(ready_a), .i_bus(i_bus_a), .sel(sel_a), .bit_valid(bv_a),
    .frame_start(fs_a), .frame_end(fe_a), .o_fb(o_fb_a),
    .err_cnt(err_cnt_a), .err_flag(err_flag_a)
  );

  byte_mux_serializer #(.BIT_CYCLES(1), .MSB_FIRST(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(valid_b),
    .din_ready(ready_b), .i_bus(i_bus_b), .sel(sel_b), .bit_valid(bv_b),
    .frame_start(fs_b), .frame_end(fe_b), .o_fb(o_fb_b),
    .err_cnt(err_cnt_b), .err_flag(err_flag_b)
  );

  // Observation view of whichever instance the current frame targets.
  bit         use_b;
  logic [7:0] ib_o;
  logic [2:0] sel_o;
  logic       bv_o, fs_o, fe_o, rdy_o;

  always_comb begin
    ib_o  = use_b ? i_bus_b : i_bus_a;
    sel_o = use_b ? sel_b   : sel_a;
    bv_o  = use_b ? bv_b    : bv_a;
    fs_o  = use_b ? fs_b    : fs_a;
    fe_o  = use_b ? fe_b    : fe_a;
    rdy_o = use_b ? ready_b : ready_a;
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_valid(input bit v);
    if (use_b) valid_b = v;
    else       valid_a = v;
  endtask

  // o_stream: serial bits in time order, first bit in o_stream[7].
  // nxt_at:   -1 no follow-on byte; otherwise the frame cycle at which the
  //           next table byte is presented with din_valid held high.
  typedef struct {
    logic [7:0] din;
    bit         use_b;
    logic [7:0] o_stream;
    int         nxt_at;
  } vec_t;

  localparam int NVEC = 11;
  vec_t tbl [NVEC];

  task automatic run_frame(input vec_t r, input bit started,
                           input logic [7:0] nxt_din, output bit nxt_started);
    int         bc;
    int         n;
    int         b;
    logic [2:0] first_sel;
    logic [2:0] exp_sel;
    logic       o_now;
    bc        = r.use_b ? 1 : 2;
    n         = 8 * bc;
    first_sel = r.use_b ? 3'd7 : 3'd0;
    if (!started) begin
      use_b = r.use_b;
      din   = r.din;
      set_valid(1'b1);
      #1;
      chk("ready_before_accept", 32'(rdy_o), 32'd1);
      tick();
    end
    set_valid(1'b0);
    if (r.nxt_at == 0) begin
      din = nxt_din;
      set_valid(1'b1);
    end
    for (int k = 0; k < n; k++) begin
      if ((r.nxt_at > 0) && (k == r.nxt_at)) begin
        din = nxt_din;
        set_valid(1'b1);
      end
      b       = k / bc;
      exp_sel = r.use_b ? 3'(7 - b) : 3'(b);
      o_now   = ib_o[sel_o];
      chk("bit_valid", 32'(bv_o), 32'd1);
      chk("sel", 32'(sel_o), 32'(exp_sel));
      chk("i_bus", 32'(ib_o), 32'(r.din));
      chk("mux_o", 32'(o_now), 32'(r.o_stream[7 - b]));
      chk("frame_start", 32'(fs_o), 32'(k == 0));
      chk("frame_end", 32'(fe_o), 32'(k == n - 1));
      chk("din_ready", 32'(rdy_o), 32'(k == n - 1));
      tick();
    end
    nxt_started = (r.nxt_at >= 0);
    if (!nxt_started) begin
      chk("idle_bit_valid", 32'(bv_o), 32'd0);
      chk("idle_sel", 32'(sel_o), 32'(first_sel));
      chk("idle_ready", 32'(rdy_o), 32'd1);
      chk("idle_i_bus", 32'(ib_o), 32'(r.din));
    end
    $display("frame dut=%s din=%02h cycles=%0d next=%0d checks=%0d failures=%0d",
             r.use_b ? "b" : "a", r.din, n, r.nxt_at, checks, failures);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_bv_a"},  32'(bv_a), 32'd0);
    chk({tag, "_fs_a"},  32'(fs_a), 32'd0);
    chk({tag, "_fe_a"},  32'(fe_a), 32'd0);
    chk({tag, "_rdy_a"}, 32'(ready_a), 32'd1);
    chk({tag, "_sel_a"}, 32'(sel_a), 32'd0);
    chk({tag, "_ibus_a"}, 32'(i_bus_a), 32'h00);
    chk({tag, "_err_a"}, 32'(err_cnt_a), 32'd0);
    chk({tag, "_flag_a"}, 32'(err_flag_a), 32'd0);
    chk({tag, "_bv_b"},  32'(bv_b), 32'd0);
    chk({tag, "_rdy_b"}, 32'(ready_b), 32'd1);
    chk({tag, "_sel_b"}, 32'(sel_b), 32'd7);
    chk({tag, "_ibus_b"}, 32'(i_bus_b), 32'h00);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit         started;
    bit         nstart;
    logic [7:0] nxt;
    vec_t       rv;

    //            din    dut   o_stream      nxt_at
    tbl[0]  = '{8'hA5, 1'b0, 8'b10100101, -1};
    tbl[1]  = '{8'h3C, 1'b0, 8'b00111100,  0};  // back-to-back into 0xC3
    tbl[2]  = '{8'hC3, 1'b0, 8'b11000011, -1};
    tbl[3]  = '{8'h3C, 1'b0, 8'b00111100,  5};  // 0x55 waits mid-frame
    tbl[4]  = '{8'h55, 1'b0, 8'b10101010, -1};
    tbl[5]  = '{8'h01, 1'b0, 8'b10000000, -1};
    tbl[6]  = '{8'h01, 1'b1, 8'b00000001, -1};
    tbl[7]  = '{8'hA5, 1'b1, 8'b10100101,  0};
    tbl[8]  = '{8'h80, 1'b1, 8'b10000000, -1};
    tbl[9]  = '{8'h36, 1'b1, 8'b00110110, -1};
    tbl[10] = '{8'hF0, 1'b0, 8'b00001111, -1};

    rst_n     = 1'b0;
    din       = 8'h00;
    valid_a   = 1'b0;
    valid_b   = 1'b0;
    fb_force0 = 1'b0;
    use_b     = 1'b0;
    repeat (2) tick();
    chk_reset_vals("reset");
    rst_n = 1'b1;
    tick();

    // Table-driven frames.
    started = 1'b0;
    for (int i = 0; i < NVEC; i++) begin
      nxt = (i + 1 < NVEC) ? tbl[i + 1].din : 8'h00;
      run_frame(tbl[i], started, nxt, nstart);
      started = nstart;
    end

    // Reset during bit 3 of an LSB-first frame, then a full 0xFF frame.
    use_b   = 1'b0;
    din     = 8'h5A;
    valid_a = 1'b1;
    #1;
    chk("rst_seq_ready", 32'(ready_a), 32'd1);
    tick();
    valid_a = 1'b0;
    repeat (6) tick();
    chk("rst_seq_sel_bit3", 32'(sel_a), 32'd3);
    chk("rst_seq_bv", 32'(bv_a), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("midrst_no_frame_end", 32'(fe_a), 32'd0);
    end
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", 32'(bv_a), 32'd0);
    rv = '{8'hFF, 1'b0, 8'b11111111, -1};
    run_frame(rv, 1'b0, 8'h00, nstart);

    // 200 random bytes through dut_b with the mux model on o_fb.
    use_b = 1'b1;
    for (int i = 0; i < 200; i++) begin
      din     = 8'($urandom_range(0, 255));
      valid_b = 1'b1;
      tick();
      valid_b = 1'b0;
      repeat (8) tick();
    end
    chk("random_idle", 32'(bv_b), 32'd0);
    chk("random_err_cnt", 32'(err_cnt_b), 32'd0);
    chk("random_err_flag", 32'(err_flag_b), 32'd0);
    $display("random frames=200 dut=b err_cnt=%0d", err_cnt_b);

    // Feedback stuck low on dut_a with 0xFF: every bit mismatches when the
    // checker is built in.
    fb_force0 = 1'b1;
    rv = '{8'hFF, 1'b0, 8'b11111111, -1};
    run_frame(rv, 1'b0, 8'h00, nstart);
    fb_force0 = 1'b0;
`ifdef SER_ERRCHK_EN
    chk("forced_err_cnt", 32'(err_cnt_a), 32'd8);
    chk("forced_err_flag", 32'(err_flag_a), 32'd1);
`else
    chk("forced_err_cnt", 32'(err_cnt_a), 32'd0);
    chk("forced_err_flag", 32'(err_flag_a), 32'd0);
`endif
    $display("forced feedback dut=a err_cnt=%0d err_flag=%0d", err_cnt_a, err_flag_a);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
